demux2_stream: RTL and testbench
================================

# demux2_stream

Registered 1-to-2 stream demultiplexer: the receive-side counterpart to the 2:1 mux. It accepts one valid/ready input stream tagged with a select bit and steers each word to one of two output streams. Each output has a private 2-entry buffer, so a stalled output never blocks traffic already queued for the other. It also keeps a wrapping count of words delivered per output. It sits between a single producer and two independent consumers in the combinational/stream datapath.

## Interface
- W, 8: data width in bits
- CW, 8: width of per-output delivered-word counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted this cycle when high together with in_valid
- in_sel  in  1  destination: 0 selects out0, 1 selects out1; sampled with the word
- in_d  in  W  input data
- out0_valid / out1_valid  out  1  head of the corresponding buffer is valid
- out0_ready / out1_ready  in  1  consumer accepts the head word
- out0_d / out1_d  out  W  head word of the corresponding buffer
- cnt0 / cnt1  out  CW  words popped from the corresponding output, wrapping modulo 2^CW

## Operation
- Each output buffer is a 2-entry FIFO with states EMPTY, ONE, FULL.
- Push to buffer N: in_valid & in_ready & (in_sel == N).
- Pop from buffer N: outN_valid & outN_ready.
- in_ready = !full[in_sel]. It is combinational on in_sel, and the other buffer's state has no effect.
- FULL plus a pop does not raise in_ready in the same cycle. There is no ready passthrough, so no combinational path exists from outN_ready to in_ready.
- State transitions per buffer:
  - EMPTY: push goes to ONE. Pop is not possible.
  - ONE: push only goes to FULL; pop only goes to EMPTY; push and pop together stay in ONE, and the head becomes the new word.
  - FULL: pop goes to ONE, and the second entry moves to the head.
- outN_valid = (state != EMPTY). outN_d is the head entry. Order within each output is strictly FIFO.
- cntN increments by 1 on every pop and wraps from 2^CW−1 to 0.
- Reset:
  - Both buffers go to EMPTY. out0_valid = out1_valid = 0, out0_d = out1_d = 0, cnt0 = cnt1 = 0.
  - in_ready = 1 in the first cycle after reset, for either value of in_sel.
  - Stored words are discarded.
  - Reset takes priority over a simultaneous push or pop.
- in_valid with in_ready low is a stall. The producer holds in_d and in_sel; the block takes no action.
- Buffer storage registers are written only on a push. The data outputs hold their value while valid is low after the first push.

## Timing
- Latency is 1 cycle: a word accepted at edge k has outN_valid high after edge k.
- Throughput is 1 word per cycle per input when the selected output drains every cycle.
- Alternating in_sel with both outputs ready sustains 1 word per cycle with no bubbles.
- All outputs except in_ready are registered. in_ready depends combinationally on in_sel and registered state only.
- cntN updates at the edge of the pop and is visible the cycle after.

## Structure
- Package demux2_pkg holds:
  - buffer state enum {EMPTY, ONE, FULL}, 2-bit encoding 00/01/10
  - BUF_DEPTH = 2
- Sub-module stream_buf2: a parameterised (W) 2-entry FIFO with push/pop, valid, full and head outputs. It is instantiated twice. The top level holds the routing logic, in_ready and the counters.

## Test plan
- Reset, then check idle state:
  - rst high for 2 cycles, then low.
  - Required: out0_valid = out1_valid = 0, cnt0 = cnt1 = 0, in_ready = 1 for in_sel = 0 and for in_sel = 1.
- Basic steering:
  - Stimulus: in_sel = 0, in_d = 8'hA5 for 1 cycle, then in_sel = 1, in_d = 8'h3C; both outputs ready.
  - Required: out0_d = A5 with valid one cycle after acceptance; out1_d = 3C one cycle after that; cnt0 = cnt1 = 1.
- Fill and backpressure:
  - Stimulus: out0_ready = 0; push 11, 22, 33 to out0.
  - Required: 11 and 22 accepted; in_ready = 0 while in_sel = 0 presenting 33; in_ready = 1 if in_sel switches to 1.
  - Then raise out0_ready. Required: out0 delivers 11, 22, 33 in order, and 33 is accepted one cycle after the first pop.
- Isolation:
  - Stimulus: out0 held FULL; stream 10 words to out1 with out1_ready = 1.
  - Required: all 10 delivered in order; cnt1 = 10; cnt0 = 0.
- Simultaneous push and pop in ONE:
  - Stimulus: out1 holds 44; push 55 in the same cycle 44 is popped.
  - Required: buffer stays in ONE, head = 55, cnt1 increments.
- Wrap and mid-operation reset:
  - Stimulus: with CW = 4, pop 17 words from out0.
  - Required: cnt0 = 1.
  - Stimulus: assert rst while both buffers are FULL.
  - Required: next cycle both valids = 0, counts = 0, and the queued words never appear.

Source files
------------

// File: rtl/demux2_pkg.sv
// demux2_pkg: shared types and constants for the 1-to-2 stream demultiplexer
package demux2_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} buf_state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/demux2_stream_buf.sv
// stream_buf2: 2-entry FIFO with registered valid/full and a shifting head entry
module stream_buf2
  import demux2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] head
);
  buf_state_t state;
  logic [W-1:0] tail;
  // push while FULL is never issued by the router, so it is ignored here
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      valid <= 1'b0;
      full  <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head  <= d;
          state <= ONE;
          valid <= 1'b1;
        end
        ONE: if (push && pop) head <= d;
        else if (push) begin
          tail  <= d;
          state <= FULL;
          full  <= 1'b1;
        end else if (pop) begin
          state <= EMPTY;
          valid <= 1'b0;
        end
        FULL: if (pop) begin
          head  <= tail;
          state <= ONE;
          full  <= 1'b0;
        end
        default: begin
          state <= EMPTY;
          valid <= 1'b0;
          full  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers one tagged valid/ready stream into two independently buffered outputs
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [W-1:0]  in_d,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [W-1:0]  out0_d,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [W-1:0]  out1_d,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);
  logic full0, full1, push0, push1, pop0, pop1;
  // ready depends only on the selected buffer's registered fullness
  assign in_ready = in_sel ? !full1 : !full0;
  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready && in_sel;
  assign pop0 = out0_valid && out0_ready;
  assign pop1 = out1_valid && out1_ready;
  stream_buf2 #(.W(W)) u_buf0 (
    .clk(clk), .rst(rst), .push(push0), .pop(pop0), .d(in_d),
    .valid(out0_valid), .full(full0), .head(out0_d)
  );
  stream_buf2 #(.W(W)) u_buf1 (
    .clk(clk), .rst(rst), .push(push1), .pop(pop1), .d(in_d),
    .valid(out1_valid), .full(full1), .head(out1_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + CW'(pop0);
      cnt1 <= cnt1 + CW'(pop1);
    end
  end
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: random and directed stimulus checked against a queue-based model
module tb_demux2_stream;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sel = 0;
  logic [W-1:0] in_d = '0, out0_d, out1_d;
  logic out0_valid, out1_valid, out0_ready = 0, out1_ready = 0;
  logic [CW-1:0] cnt0, cnt1;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] last0 = '0, last1 = '0;
  int c0 = 0, c1 = 0;

  demux2_stream #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_d(in_d), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_d(out0_d),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_d(out1_d),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    logic push, pop0, pop1;
    in_valid = v; in_sel = s; in_d = d; out0_ready = r0; out1_ready = r1;
    #1;
    chk("in_ready", in_ready, (s ? q1.size() : q0.size()) < 2);
    chk("out0_valid", out0_valid, q0.size() != 0);
    chk("out1_valid", out1_valid, q1.size() != 0);
    chk("out0_d", out0_d, q0.size() != 0 ? q0[0] : last0);
    chk("out1_d", out1_d, q1.size() != 0 ? q1[0] : last1);
    chk("cnt0", cnt0, c0 % (1 << CW));
    chk("cnt1", cnt1, c1 % (1 << CW));
    push = v && ((s ? q1.size() : q0.size()) < 2);
    pop0 = r0 && q0.size() != 0;
    pop1 = r1 && q1.size() != 0;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); c0 = 0; c1 = 0; last0 = '0; last1 = '0;
    end else begin
      if (pop0) begin void'(q0.pop_front()); c0++; end
      if (pop1) begin void'(q1.pop_front()); c1++; end
      if (push && !s) begin q0.push_back(d); last0 = d; end
      if (push && s) begin q1.push_back(d); last1 = d; end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    // idle after reset, ready for both selections
    cycle(0, 0, 0, 0, 0);
    chk("idle_ready0", in_ready, 1);
    in_sel = 1; #1;
    chk("idle_ready1", in_ready, 1);
    // basic steering
    cycle(1, 0, 8'hA5, 1, 1);
    chk("steer_a5", {out0_valid, out0_d}, {1'b1, 8'hA5});
    cycle(1, 1, 8'h3C, 1, 1);
    chk("steer_3c", {out1_valid, out1_d}, {1'b1, 8'h3C});
    cycle(0, 0, 0, 1, 1);
    chk("steer_cnt", {cnt0, cnt1}, {4'd1, 4'd1});
    // fill out0 and observe backpressure
    cycle(1, 0, 8'h11, 0, 0);
    cycle(1, 0, 8'h22, 0, 0);
    in_valid = 1; in_sel = 0; in_d = 8'h33; #1;
    chk("bp_stall", in_ready, 0);
    in_sel = 1; #1;
    chk("bp_other", in_ready, 1);
    cycle(1, 0, 8'h33, 0, 0);
    cycle(1, 0, 8'h33, 1, 0);
    chk("bp_head22", out0_d, 8'h22);
    cycle(1, 0, 8'h33, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // isolation: out0 held FULL while out1 streams
    rst = 1; cycle(0, 0, 0, 0, 0); rst = 0;
    cycle(1, 0, 8'h77, 0, 1);
    cycle(1, 0, 8'h88, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, W'(8'hC0 + i), 0, 1);
    cycle(0, 1, 0, 0, 1);
    chk("iso_cnt1", cnt1, 10);
    chk("iso_cnt0", cnt0, 0);
    // push and pop together in ONE
    cycle(1, 1, 8'h44, 0, 0);
    cycle(1, 1, 8'h55, 0, 1);
    chk("ones_head", {out1_valid, out1_d}, {1'b1, 8'h55});
    chk("ones_cnt1", cnt1, 11);
    cycle(0, 1, 0, 0, 0);
    // counter wrap after 17 pops
    rst = 1; cycle(0, 0, 0, 0, 0); rst = 0;
    for (int i = 0; i < 17; i++) cycle(1, 0, W'(i), 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("wrap_cnt0", cnt0, 1);
    // reset with both buffers full discards their contents
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, W'(8'hE0 + i), 0, 0);
      cycle(1, 1, W'(8'hF0 + i), 0, 0);
    end
    rst = 1; cycle(0, 0, 0, 1, 1); rst = 0;
    chk("rst_valids", {out0_valid, out1_valid}, 0);
    chk("rst_cnts", {cnt0, cnt1}, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end
    rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
